// File: rtl/logic_unit_seq.sv
// ============================================================================
// Module      : logic_unit_seq
// Description : Registered AND/OR/XOR/XNOR unit with single-shot and
//               burst-accumulate modes under valid/ready handshakes.
//               Optional out_parity port enabled by LOGIC_UNIT_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_beats,
`ifdef LOGIC_UNIT_PARITY_EN
  output logic             out_parity,
`endif
  output logic             out_sat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [1:0]       r_opl;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic [CNT_W-1:0] r_beats;
  logic             r_out_sat;

  logic             w_fire;
  logic             w_in_acc_state;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_ab;
  logic [WIDTH-1:0] w_fold;
  logic             w_cnt_max;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_sat_nxt;

  function automatic logic [WIDTH-1:0] f_op(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y,
                                            input logic [1:0]       op);
    case (op)
      2'b00:   f_op = x & y;
      2'b01:   f_op = x | y;
      2'b10:   f_op = x ^ y;
      default: f_op = ~(x ^ y);
    endcase
  endfunction

  assign out_valid      = (r_state == FULL);
  assign in_ready       = !out_valid || out_ready;
  assign w_fire         = in_valid && in_ready;
  assign w_in_acc_state = (r_state == ACC);

  // Inside a burst the latched op governs both the pair and the fold.
  assign w_op      = w_in_acc_state ? r_opl : in_op;
  assign w_ab      = f_op(in_a, in_b, w_op);
  assign w_fold    = f_op(r_acc, w_ab, r_opl);
  assign w_cnt_max = &r_cnt;
  assign w_cnt_inc = w_cnt_max ? r_cnt : r_cnt + CNT_W'(1);
  assign w_sat_nxt = r_sat | w_cnt_max;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC: begin
        if (w_fire && in_last) w_state_nxt = FULL;
      end
      default: begin
        if (w_fire) begin
          w_state_nxt = (in_acc && !in_last) ? ACC : FULL;
        end else if (r_state == FULL && out_ready) begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_opl     <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_y       <= '0;
      r_zero    <= 1'b0;
      r_beats   <= '0;
      r_out_sat <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        if (w_in_acc_state) begin
          if (in_last) begin
            r_y       <= w_fold;
            r_zero    <= (w_fold == '0);
            r_beats   <= w_cnt_inc;
            r_out_sat <= w_sat_nxt;
          end else begin
            r_acc <= w_fold;
            r_cnt <= w_cnt_inc;
            r_sat <= w_sat_nxt;
          end
        end else if (in_acc && !in_last) begin
          r_acc <= w_ab;
          r_opl <= in_op;
          r_cnt <= CNT_W'(1);
          r_sat <= 1'b0;
        end else begin
          r_y       <= w_ab;
          r_zero    <= (w_ab == '0);
          r_beats   <= CNT_W'(1);
          r_out_sat <= 1'b0;
        end
      end
    end
  end

`ifdef LOGIC_UNIT_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_fire) begin
      if (w_in_acc_state) begin
        if (in_last) r_parity <= ^w_fold;
      end else if (!(in_acc && !in_last)) begin
        r_parity <= ^w_ab;
      end
    end
  end

  assign out_parity = r_parity;
`endif

  assign out_y     = r_y;
  assign out_zero  = r_zero;
  assign out_beats = r_beats;
  assign out_sat   = r_out_sat;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_seq.sv
// ============================================================================
// Module      : tb_logic_unit_seq
// Description : Directed self-checking bench for logic_unit_seq (two instances:
//               CNT_W=8 and CNT_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_unit_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, v1;
  logic [7:0] a, b;
  logic [1:0] op;
  logic       acc, last, out_ready;

  logic       rdy0, val0, zero0, sat0;
  logic [7:0] y0, beats0;
  logic       rdy1, val1, zero1, sat1;
  logic [7:0] y1;
  logic [1:0] beats1;
`ifdef LOGIC_UNIT_PARITY_EN
  logic       par0, par1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic_unit_seq #(.WIDTH(8), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0),
    .in_a(a), .in_b(b), .in_op(op), .in_acc(acc), .in_last(last),
    .out_valid(val0), .out_ready(out_ready), .out_y(y0), .out_zero(zero0),
    .out_beats(beats0),
`ifdef LOGIC_UNIT_PARITY_EN
    .out_parity(par0),
`endif
    .out_sat(sat0)
  );

  logic_unit_seq #(.WIDTH(8), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
    .in_a(a), .in_b(b), .in_op(op), .in_acc(acc), .in_last(last),
    .out_valid(val1), .out_ready(out_ready), .out_y(y1), .out_zero(zero1),
    .out_beats(beats1),
`ifdef LOGIC_UNIT_PARITY_EN
    .out_parity(par1),
`endif
    .out_sat(sat1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; a = '0; b = '0; op = '0;
    acc = 1'b0; last = 1'b0; out_ready = 1'b0;
    tick();
    check("rst_valid", 32'(val0), 32'd0);
    check("rst_y", 32'(y0), 32'd0);
    check("rst_beats", 32'(beats0), 32'd0);
    check("rst_zero", 32'(zero0), 32'd0);
    check("rst_sat", 32'(sat0), 32'd0);
    check("rst_ready", 32'(rdy0), 32'd1);
    rst_n = 1'b1;

    // Single AND
    v0 = 1'b1; op = 2'b00; a = 8'hF0; b = 8'h3C;
    tick();
    v0 = 1'b0;
    check("and_valid", 32'(val0), 32'd1);
    check("and_y", 32'(y0), 32'h30);
    check("and_beats", 32'(beats0), 32'd1);
    check("and_zero", 32'(zero0), 32'd0);
    check("full_ready_lo", 32'(rdy0), 32'd0);

    // Single XOR consumed alongside previous result, then XNOR back-to-back
    out_ready = 1'b1;
    v0 = 1'b1; op = 2'b10; a = 8'h5A; b = 8'h5A;
    #1 check("full_ready_hi", 32'(rdy0), 32'd1);
    tick();
    check("xor_y", 32'(y0), 32'h00);
    check("xor_zero", 32'(zero0), 32'd1);
    check("xor_valid", 32'(val0), 32'd1);
    op = 2'b11; a = 8'h0F; b = 8'hFF;
    tick();
    v0 = 1'b0;
    check("xnor_y", 32'(y0), 32'h0F);
    check("xnor_valid", 32'(val0), 32'd1);
    check("xnor_zero", 32'(zero0), 32'd0);
    tick();
    check("drain_valid", 32'(val0), 32'd0);
    check("drain_y_kept", 32'(y0), 32'h0F);

    // OR burst with in_op changed mid-burst
    out_ready = 1'b0;
    v0 = 1'b1; op = 2'b01; acc = 1'b1; a = 8'h01; b = 8'h02;
    tick();
    check("burst_valid0", 32'(val0), 32'd0);
    op = 2'b00; acc = 1'b0; a = 8'h04; b = 8'h00;
    tick();
    check("burst_valid1", 32'(val0), 32'd0);
    a = 8'h80; b = 8'h10; last = 1'b1;
    tick();
    v0 = 1'b0; last = 1'b0;
    check("burst_valid", 32'(val0), 32'd1);
    check("burst_y", 32'(y0), 32'h97);
    check("burst_beats", 32'(beats0), 32'd3);
    check("burst_sat", 32'(sat0), 32'd0);

    // Backpressure: offered beat must wait
    v0 = 1'b1; op = 2'b01; a = 8'h11; b = 8'h22;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ready", 32'(rdy0), 32'd0);
      check("bp_y", 32'(y0), 32'h97);
    end
    check("bp_beats", 32'(beats0), 32'd3);
    out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(rdy0), 32'd1);
    tick();
    v0 = 1'b0;
    check("bp_new_valid", 32'(val0), 32'd1);
    check("bp_new_y", 32'(y0), 32'h33);
    check("bp_new_beats", 32'(beats0), 32'd1);
    tick();
    check("bp_idle", 32'(val0), 32'd0);

    // Saturating counter on the CNT_W=2 instance
    out_ready = 1'b0;
    v1 = 1'b1; op = 2'b10; acc = 1'b1; a = 8'h01; b = 8'h00;
    tick();
    acc = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    last = 1'b1;
    tick();
    v1 = 1'b0; last = 1'b0;
    check("sat_valid", 32'(val1), 32'd1);
    check("sat_y", 32'(y1), 32'h01);
    check("sat_beats", 32'(beats1), 32'd3);
    check("sat_flag", 32'(sat1), 32'd1);
    check("sat_u0_idle", 32'(val0), 32'd0);

    // Reset during a burst after two beats
    out_ready = 1'b1;
    tick();
    v0 = 1'b1; op = 2'b01; acc = 1'b1; a = 8'h01; b = 8'h02;
    tick();
    acc = 1'b0; a = 8'h04;
    tick();
    v0 = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(val0), 32'd0);
    check("mid_rst_y", 32'(y0), 32'd0);
    check("mid_rst_beats", 32'(beats0), 32'd0);
    check("mid_rst_zero", 32'(zero0), 32'd0);
    check("mid_rst_ready", 32'(rdy0), 32'd1);
    check("mid_rst_u1_sat", 32'(sat1), 32'd0);
    v0 = 1'b1; op = 2'b00; a = 8'hFF; b = 8'hAA;
    tick();
    v0 = 1'b0;
    check("post_rst_valid", 32'(val0), 32'd1);
    check("post_rst_y", 32'(y0), 32'hAA);
    check("post_rst_beats", 32'(beats0), 32'd1);
`ifdef LOGIC_UNIT_PARITY_EN
    check("post_rst_parity", 32'(par0), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
